fpaddsub_arbiter: RTL

Round-robin scheduler that shares one pipelined single-precision FPAddSub datapath (align, add, normalise, round) among `NREQ` requesters. It accepts operand/op/rounding-mode requests over valid/ready handshakes and issues at most one operation per cycle into the datapath. It tracks each in-flight operation's requester tag through the datapath latency and routes each result and its inexact flag back to the requester that issued it. It sits between the FP client ports and the single FPAddSub instance.

---
 rtl/fpaddsub_pkg.sv | 26 ++
 rtl/fpaddsub_rr_arb.sv | 48 ++++
 rtl/fpaddsub_arbiter.sv | 138 +++++++++++++
 3 files changed

// File: rtl/fpaddsub_pkg.sv
// Shared constants and helpers for the FP add/sub scheduler and its clients.
package fpaddsub_pkg;

  localparam int unsigned FP_W = 32;

  localparam logic [1:0] RM_RNE = 2'b00;
  localparam logic [1:0] RM_RTZ = 2'b01;
  localparam logic [1:0] RM_RUP = 2'b10;
  localparam logic [1:0] RM_RDN = 2'b11;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  function automatic int unsigned fp_clog2(input int unsigned n);
    int unsigned r;
    r = 0;
    for (int unsigned v = n - 1; v != 0; v = v >> 1) r++;
    return r;
  endfunction

  // A single requester still needs one tag bit to keep the vectors legal.
  function automatic int unsigned tag_w(input int unsigned n);
    return (n <= 1) ? 1 : fp_clog2(n);
  endfunction

endpackage

// File: rtl/fpaddsub_rr_arb.sv
// Round-robin arbiter: combinational search from a registered pointer,
// pointer moves past the winner whenever a grant is made.
module fpaddsub_rr_arb
  import fpaddsub_pkg::*;
#(
  parameter int unsigned N  = 4,
  parameter int unsigned IW = tag_w(N)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [N-1:0]  req_i,
  output logic [N-1:0]  gnt_o,
  output logic          gnt_any_o,
  output logic [IW-1:0] gnt_idx_o
);

  logic [IW-1:0] ptr_q, ptr_d;
  int unsigned   idx;

  always_comb begin
    gnt_o     = '0;
    gnt_any_o = 1'b0;
    gnt_idx_o = '0;
    idx       = 0;
    for (int unsigned k = 0; k < N; k++) begin
      idx = int'(ptr_q) + k;
      if (idx >= N) idx = idx - N;
      if (!gnt_any_o && req_i[idx]) begin
        gnt_o[idx] = 1'b1;
        gnt_any_o  = 1'b1;
        gnt_idx_o  = IW'(idx);
      end
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (gnt_any_o) begin
      ptr_d = (gnt_idx_o == IW'(N - 1)) ? '0 : gnt_idx_o + IW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ptr_q <= '0;
    else        ptr_q <= ptr_d;
  end

endmodule

// File: rtl/fpaddsub_arbiter.sv
// Shares one fixed-latency FPAddSub datapath among NREQ requesters: grants,
// issues, tracks requester tags through the pipe and routes results back.
module fpaddsub_arbiter
  import fpaddsub_pkg::*;
#(
  parameter int unsigned NREQ = 4,
  parameter int unsigned LAT  = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       en,
  input  logic [NREQ-1:0]            req_valid,
  output logic [NREQ-1:0]            req_ready,
  input  logic [FP_W*NREQ-1:0]       req_a,
  input  logic [FP_W*NREQ-1:0]       req_b,
  input  logic [NREQ-1:0]            req_op,
  input  logic [2*NREQ-1:0]          req_mode,
  output logic                       fp_issue,
  output logic [FP_W-1:0]            fp_a,
  output logic [FP_W-1:0]            fp_b,
  output logic                       fp_op,
  output logic [1:0]                 fp_mode,
  input  logic [FP_W-1:0]            fp_result,
  input  logic                       fp_inexact,
  output logic [NREQ-1:0]            rsp_valid,
  output logic [FP_W-1:0]            rsp_result,
  output logic                       rsp_inexact,
  output logic                       busy,
  output logic [fp_clog2(LAT+2)-1:0] outstanding
);

  localparam int unsigned TW = tag_w(NREQ);
  localparam int unsigned OW = fp_clog2(LAT + 2);

  logic [NREQ-1:0] arb_req;
  logic            hs;
  logic [TW-1:0]   gnt_idx;

  logic            iss_vld_q;
  logic [FP_W-1:0] a_q, a_d;
  logic [FP_W-1:0] b_q, b_d;
  logic            op_q, op_d;
  logic [1:0]      mode_q, mode_d;
  logic [TW-1:0]   tag_q;

  logic [LAT-1:0]  pv_q;
  logic [TW-1:0]   pt_q [LAT];
  logic            rsp_fire;

  logic [OW-1:0]   out_q, out_d;

  // Masking with rst_n keeps req_ready low for the whole reset window.
  assign arb_req = req_valid & {NREQ{en & rst_n}};

  fpaddsub_rr_arb #(
    .N  (NREQ),
    .IW (TW)
  ) u_arb (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_i     (arb_req),
    .gnt_o     (req_ready),
    .gnt_any_o (hs),
    .gnt_idx_o (gnt_idx)
  );

  always_comb begin
    a_d    = req_a[FP_W*int'(gnt_idx) +: FP_W];
    b_d    = req_b[FP_W*int'(gnt_idx) +: FP_W];
    op_d   = req_op[gnt_idx];
    mode_d = req_mode[2*int'(gnt_idx) +: 2];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      iss_vld_q <= 1'b0;
      a_q       <= '0;
      b_q       <= '0;
      op_q      <= OP_ADD;
      mode_q    <= RM_RNE;
      tag_q     <= '0;
    end else begin
      iss_vld_q <= hs;
      if (hs) begin
        a_q    <= a_d;
        b_q    <= b_d;
        op_q   <= op_d;
        mode_q <= mode_d;
        tag_q  <= gnt_idx;
      end
    end
  end

  assign fp_issue = iss_vld_q;
  assign fp_a     = a_q;
  assign fp_b     = b_q;
  assign fp_op    = op_q;
  assign fp_mode  = mode_q;

  // Stage k holds the op issued k+1 cycles ago; the last stage lines up with fp_result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pv_q <= '0;
      for (int s = 0; s < LAT; s++) pt_q[s] <= '0;
    end else begin
      pv_q[0] <= iss_vld_q;
      pt_q[0] <= tag_q;
      for (int s = 1; s < LAT; s++) begin
        pv_q[s] <= pv_q[s-1];
        pt_q[s] <= pt_q[s-1];
      end
    end
  end

  assign rsp_fire    = pv_q[LAT-1];
  assign rsp_result  = fp_result;
  assign rsp_inexact = fp_inexact;

  always_comb begin
    rsp_valid = '0;
    if (rsp_fire) rsp_valid[pt_q[LAT-1]] = 1'b1;
  end

  always_comb begin
    out_d = out_q;
    if (hs && !rsp_fire)      out_d = out_q + OW'(1);
    else if (!hs && rsp_fire) out_d = out_q - OW'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) out_q <= '0;
    else        out_q <= out_d;
  end

  assign outstanding = out_q;
  assign busy        = (out_q != '0);

endmodule
